// File: rtl/gpu_pkg.sv
// Shared constants for the GPU/DSP flag and condition logic.
// Flag vector layout is {N,C,Z}.
package gpu_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  localparam int COND_ZCLR = 0;
  localparam int COND_ZSET = 1;
  localparam int COND_FCLR = 2;
  localparam int COND_FSET = 3;
  localparam int COND_SEL  = 4;

  localparam int STK_DEPTH = 2;

endpackage

// File: rtl/gpu_cond_eval.sv
// Combinational jump-condition evaluator over {N,C,Z}.
// Shared by the flag stage and the DSP pipeline.
module gpu_cond_eval
  import gpu_pkg::*;
(
  input  logic [4:0] cond,
  input  logic [2:0] flags,
  output logic       cond_true
);

  logic w_z;
  logic w_sel;
  logic w_zclr_ok;
  logic w_zset_ok;
  logic w_fclr_ok;
  logic w_fset_ok;

  assign w_z = flags[FLAG_Z];

  // Bit 4 picks which flag bits 2/3 test: C when clear, N when set.
  assign w_sel = cond[COND_SEL] ? flags[FLAG_N]
                                : flags[FLAG_C];

  assign w_zclr_ok = ~cond[COND_ZCLR] | ~w_z;
  assign w_zset_ok = ~cond[COND_ZSET] | w_z;
  assign w_fclr_ok = ~cond[COND_FCLR] | ~w_sel;
  assign w_fset_ok = ~cond[COND_FSET] | w_sel;

  assign cond_true = w_zclr_ok & w_zset_ok
                   & w_fclr_ok & w_fset_ok;

endmodule

// File: rtl/gpu_flags.sv
// Condition-flag register, 2-deep interrupt flag stack
// and registered jump-condition result with interlock.
module gpu_flags
  import gpu_pkg::*;
(
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       result_zero,
  input  logic       result_sign,
  input  logic       carry_in,
  input  logic       flag_wr,
  input  logic       carry_wr,
  input  logic       flag_ld,
  input  logic [2:0] flag_din,
  input  logic       int_save,
  input  logic       int_restore,
  input  logic       err_clr,
  input  logic       cond_req,
  input  logic [4:0] cond,
  output logic [2:0] flags_q,
  output logic       cond_stall,
  output logic       cond_valid,
  output logic       cond_true,
  output logic [1:0] stk_depth,
  output logic       stk_err
);

  localparam logic [1:0] DEPTH_FULL = 2'(STK_DEPTH);

  logic [2:0] r_flags;
  logic [2:0] r_top;
  logic [2:0] r_bot;
  logic [1:0] r_depth;
  logic       r_err;
  logic       r_cvalid;
  logic       r_ctrue;

  logic w_empty;
  logic w_full;
  logic w_err_new;
  logic w_accept;
  logic w_eval;

  assign w_empty = (r_depth == 2'd0);
  assign w_full  = (r_depth == DEPTH_FULL);

  // Underflow on empty pop; overflow on a pure push when full.
  assign w_err_new = (int_restore & w_empty)
                   | (int_save & ~int_restore & w_full);

  assign cond_stall = cond_req
                    & (flag_wr | flag_ld | int_restore);
  assign w_accept   = cond_req & ~cond_stall;

  gpu_cond_eval u_eval (
    .cond      (cond),
    .flags     (r_flags),
    .cond_true (w_eval)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
    end else if (int_restore) begin
      if (!w_empty)
        r_flags <= r_top;
    end else if (flag_ld) begin
      r_flags <= flag_din;
    end else if (flag_wr) begin
      r_flags[FLAG_Z] <= result_zero;
      r_flags[FLAG_N] <= result_sign;
      if (carry_wr)
        r_flags[FLAG_C] <= carry_in;
    end
  end

  // Pushes always store the flags from before this edge.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_top   <= '0;
      r_bot   <= '0;
      r_depth <= '0;
    end else if (int_save && int_restore) begin
      r_top <= r_flags;
      if (w_empty)
        r_depth <= 2'd1;
    end else if (int_save) begin
      r_top <= r_flags;
      r_bot <= r_top;
      if (!w_full)
        r_depth <= r_depth + 2'd1;
    end else if (int_restore && !w_empty) begin
      r_top   <= r_bot;
      r_bot   <= '0;
      r_depth <= r_depth - 2'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)
      r_err <= 1'b0;
    else if (w_err_new)
      r_err <= 1'b1;
    else if (err_clr)
      r_err <= 1'b0;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_cvalid <= 1'b0;
      r_ctrue  <= 1'b0;
    end else begin
      r_cvalid <= w_accept;
      r_ctrue  <= w_accept & w_eval;
    end
  end

  assign flags_q    = r_flags;
  assign stk_depth  = r_depth;
  assign stk_err    = r_err;
  assign cond_valid = r_cvalid;
  assign cond_true  = r_ctrue;

endmodule

// File: doc/gpu_flags.md
# gpu_flags

Condition-flag register and jump-condition evaluator for the GPU/DSP ALU result stage. It sits directly downstream of the 32-bit zero detector on the ALU result bus. It latches Z (from the zero detector), N (result bit 31) and C (adder carry) on flag-writing instructions. It also holds a 2-deep interrupt flag stack and evaluates 5-bit JUMP/JR condition codes against the committed flags, with an interlock when a flag update is in flight.

## Interface
Parameters: none. Stack depth is fixed at 2.

Ports:
- sys_clk  in  1  — system clock, all state on rising edge
- reset  in  1  — asynchronous, active-high; clears all state
- result_zero  in  1  — zero-detect output for the current ALU result (1 = result is zero)
- result_sign  in  1  — ALU result bit 31
- carry_in  in  1  — ALU carry/borrow out
- flag_wr  in  1  — current instruction updates Z and N
- carry_wr  in  1  — current instruction updates C; only honoured with flag_wr
- flag_ld  in  1  — direct load of flags (move-to-flags)
- flag_din  in  3  — {N,C,Z} load value
- int_save  in  1  — push current flags (interrupt entry)
- int_restore  in  1  — pop flags (interrupt return)
- err_clr  in  1  — clear stk_err
- cond_req  in  1  — evaluate condition
- cond  in  5  — condition code
- flags_q  out  3  — committed {N,C,Z}
- cond_stall  out  1  — combinational; request not accepted this cycle
- cond_valid  out  1  — registered; result for the request accepted last cycle
- cond_true  out  1  — registered; condition result, valid with cond_valid
- stk_depth  out  2  — stack occupancy, 0..2
- stk_err  out  1  — sticky stack overflow/underflow

Decided: one clock; reset is asynchronous and active-high.

## Operation
- Flag update priority, highest first: reset, int_restore, flag_ld, flag_wr.
- flag_wr: Z ← result_zero, N ← result_sign. C ← carry_in if carry_wr, else C is unchanged.
- flag_ld: {N,C,Z} ← flag_din.
- int_restore with stk_depth > 0: flags ← top entry, depth decrements.
- int_restore with stk_depth = 0: flags unchanged, stk_err set.
- int_save pushes the flags as they were before this edge's update.
  - Depth 2 push: oldest entry is discarded, depth stays 2, stk_err set.
- int_save and int_restore in the same cycle: restore takes priority. The pop occurs, then the pre-update flags are pushed. Net depth is unchanged and the top entry becomes the old flags.
- stk_err is sticky. err_clr clears it. If err_clr and a new error occur in the same cycle, the new error wins and stk_err stays 1.
- Condition evaluation:
  - cond[4] = 0 selects C for bits 2/3; cond[4] = 1 selects N.
  - Bit 0 requires Z=0. Bit 1 requires Z=1. Bit 2 requires the selected flag = 0. Bit 3 requires the selected flag = 1.
  - cond_true is the AND of all selected requirements.
  - cond=0 is always true. Contradictory codes (e.g. bits 0 and 1 both set) are never true.
- Interlock: cond_stall = cond_req & (flag_wr | flag_ld | int_restore). A stalled request is not accepted; the requester holds cond_req and cond stable until the stall drops.

## Timing
- Reset values: flags_q=000, stack entries 000, stk_depth=0, stk_err=0, cond_valid=0, cond_true=0.
- Flag update latency: the input is sampled at edge n and is visible on flags_q after edge n.
- Condition latency: a request accepted at edge n (cond_req & ~cond_stall) gives cond_valid=1 and cond_true after edge n. Both are valid for exactly one cycle.
- Condition after a flag write: flag_wr in cycle k plus cond_req in cycle k → stall in k. The request is accepted in k+1 using the new flags, and the result appears in k+2.
- cond_valid=0 in any cycle following a non-accepted cycle.
- Reset asserted mid-stack or mid-request: all state clears immediately, and no cond_valid is produced for the pending request.

## Structure
- Shared package gpu_pkg holds:
  - flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_N=2
  - condition field bit positions
  - the stack depth constant
- One natural sub-module: gpu_cond_eval, purely combinational, taking (cond, flags) to the result. It is reused by the DSP pipeline.
- The stack and flag register stay in gpu_flags.

## Test plan
- Reset, then flag_wr with result_zero=1, result_sign=0, carry_wr=1, carry_in=1 → flags_q=011 next cycle. Then cond=00010 evaluates true one cycle after acceptance.
- flag_wr with carry_wr=0 and carry_in=0 while C=1 → C stays 1; Z and N take the new values.
- cond_req with cond=00001 in the same cycle as flag_wr setting Z=1 → cond_stall=1. The request is accepted next cycle with cond_true=0, and cond_valid appears 2 cycles after the original request.
- int_save ×3 with flags 001, 010, 100 → stk_depth=2, stk_err=1. Two int_restores give flags 100 then 010. A third restore leaves flags at 010.
- Simultaneous int_save and int_restore at depth 1 with stack top=101 and flags=010 → flags=101, depth=1, top=010.
- Sweep all 32 cond values against all 8 flag combinations → results match the gpu_cond_eval reference model. cond=0 is always true; cond=00011 is never true.
